// File: rtl/seq_multi_op_adder.sv
// Sequential accumulating adder: sums a framed stream of operands, each added or
// subtracted, and presents the frame result with sticky overflow and truncation flags.
module seq_multi_op_adder #(
    parameter int WIDTH   = 4,
    parameter int MAX_OPS = 8,
    parameter int CNT_W   = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             out_trunc,
    output logic [CNT_W-1:0] out_count,
    output logic             err_seq
);

    // Handshake: a beat moves on a rising edge with in_valid && in_ready; a result
    // moves with out_valid && out_ready. Neither valid depends on its ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] acc, acc_next;
    logic             ovf, ovf_next;
    logic [CNT_W-1:0] count, count_next;
    logic             err_next;
    logic             trunc_next;
    logic             finish;

    logic             beat;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH-1:0] load_sum;
    logic             load_ovf;
    logic [CNT_W-1:0] count_inc;

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign beat      = in_valid && in_ready;

    // Extra top bit carries the carry-out of an add or the borrow of a subtract.
    assign add_ext   = {1'b0, acc} + {1'b0, in_data};
    assign sub_ext   = {1'b0, acc} - {1'b0, in_data};
    assign load_sum  = in_sub ? ({WIDTH{1'b0}} - in_data) : in_data;
    assign load_ovf  = in_sub && (in_data != '0);
    assign count_inc = count + CNT_W'(1);

    always_comb begin
        state_next = state;
        acc_next   = acc;
        ovf_next   = ovf;
        count_next = count;
        err_next   = 1'b0;
        trunc_next = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (beat) begin
                    if (in_first) begin
                        acc_next   = load_sum;
                        ovf_next   = load_ovf;
                        count_next = CNT_W'(1);
                        if (in_last) begin
                            state_next = DONE;
                            finish     = 1'b1;
                        end else begin
                            state_next = ACCUM;
                        end
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (beat) begin
                    if (in_first) begin
                        // A stray first beat abandons the partial frame and starts over.
                        acc_next   = load_sum;
                        ovf_next   = load_ovf;
                        count_next = CNT_W'(1);
                        err_next   = 1'b1;
                        if (in_last) begin
                            state_next = DONE;
                            finish     = 1'b1;
                        end
                    end else begin
                        acc_next   = in_sub ? sub_ext[WIDTH-1:0] : add_ext[WIDTH-1:0];
                        ovf_next   = ovf | (in_sub ? sub_ext[WIDTH] : add_ext[WIDTH]);
                        count_next = count_inc;
                        if (in_last) begin
                            state_next = DONE;
                            finish     = 1'b1;
                        end else if (count_inc == CNT_W'(MAX_OPS)) begin
                            state_next = DONE;
                            finish     = 1'b1;
                            trunc_next = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            count     <= '0;
            err_seq   <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_trunc <= 1'b0;
            out_count <= '0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            ovf     <= ovf_next;
            count   <= count_next;
            err_seq <= err_next;
            // Result registers change only when a frame completes, so they stay
            // stable through DONE and keep the last result while idle.
            if (finish) begin
                out_sum   <= acc_next;
                out_ovf   <= ovf_next;
                out_trunc <= trunc_next;
                out_count <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_seq_multi_op_adder.sv
// Bench for seq_multi_op_adder: directed framing scenarios plus random frames
// compared against an integer-arithmetic model of the frame sum.
module tb_seq_multi_op_adder;

    localparam int W   = 4;
    localparam int MO  = 4;
    localparam int CW  = $clog2(MO + 1);
    localparam int MOD = 1 << W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_first;
    logic          in_last;
    logic          in_sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_ovf;
    logic          out_trunc;
    logic [CW-1:0] out_count;
    logic          err_seq;

    int checks;
    int errors;

    seq_multi_op_adder #(.WIDTH(W), .MAX_OPS(MO)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_trunc (out_trunc),
        .out_count (out_count),
        .err_seq   (err_seq)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: called at a falling edge; returns at the falling edge after the accept.
    task automatic drive_beat(input logic f, input logic l, input logic s,
                              input logic [W-1:0] d, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        in_sub   = s;
        in_data  = d;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_first = $urandom_range(0, 1);
        in_last  = $urandom_range(0, 1);
        in_sub   = $urandom_range(0, 1);
        in_data  = W'($urandom_range(0, MOD - 1));
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Reference model: running sum kept as a plain integer, wrapped into range.
    task automatic model_frame(input int n, input int d[MO], input bit s[MO], input bit l[MO],
                               output int sum, output bit ovf, output int cnt, output bit trunc);
        int r;
        r = 0; ovf = 0; cnt = 0; trunc = 0;
        for (int i = 0; i < n; i++) begin
            if (s[i]) r = r - d[i];
            else      r = r + d[i];
            if (r < 0)    begin ovf = 1; r = r + MOD; end
            if (r >= MOD) begin ovf = 1; r = r - MOD; end
            cnt++;
            if (l[i]) break;
            if (cnt == MO) begin trunc = 1; break; end
        end
        sum = r;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid, out_sum, out_ovf, out_trunc, out_count, err_seq} !==
            {1'b1, 1'b0, W'(0), 1'b0, 1'b0, CW'(0), 1'b0}) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b sum=%0d ovf=%b tr=%b cnt=%0d err=%b, want rdy=1 rest 0",
                     in_ready, out_valid, out_sum, out_ovf, out_trunc, out_count, err_seq);
        end
    endtask

    task automatic test_basic();
        bit ok;
        out_ready = 1'b1;
        drive_beat(1, 0, 0, 4'd2, ok);
        checks++;
        if (ok !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_first: ok=%b vld=%b want ok=1 vld=0", ok, out_valid);
        end
        drive_beat(0, 1, 0, 4'd3, ok);
        checks++;
        if (ok !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL basic_latency: ok=%b vld=%b want 1 1", ok, out_valid);
        end
        checks++;
        if ({out_sum, out_ovf, out_count, out_trunc} !== {4'd5, 1'b0, CW'(2), 1'b0}) begin
            errors++;
            $display("FAIL basic_result: sum=%0d ovf=%b cnt=%0d tr=%b want 5 0 2 0",
                     out_sum, out_ovf, out_count, out_trunc);
        end
        accept_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_release: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        drive_beat(1, 0, 0, 4'd9, ok);
        drive_beat(0, 1, 0, 4'd8, ok);
        checks++;
        if ({ok, out_valid, out_sum, out_ovf} !== {1'b1, 1'b1, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_add: ok=%b vld=%b sum=%0d ovf=%b want 1 1 1 1", ok, out_valid, out_sum, out_ovf);
        end
        accept_result();
        drive_beat(1, 0, 0, 4'd3, ok);
        drive_beat(0, 1, 1, 4'd5, ok);
        checks++;
        if ({ok, out_valid, out_sum, out_ovf} !== {1'b1, 1'b1, 4'd14, 1'b1}) begin
            errors++;
            $display("FAIL ovf_sub: ok=%b vld=%b sum=%0d ovf=%b want 1 1 14 1", ok, out_valid, out_sum, out_ovf);
        end
        accept_result();
    endtask

    task automatic test_trunc_backpressure();
        bit ok;
        drive_beat(1, 0, 0, 4'd1, ok);
        for (int i = 0; i < 3; i++) drive_beat(0, 0, 0, 4'd1, ok);
        checks++;
        if ({out_valid, out_sum, out_trunc, out_count, out_ovf} !== {1'b1, 4'd4, 1'b1, CW'(4), 1'b0}) begin
            errors++;
            $display("FAIL trunc: vld=%b sum=%0d tr=%b cnt=%0d ovf=%b want 1 4 1 4 0",
                     out_valid, out_sum, out_trunc, out_count, out_ovf);
        end
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_data = 4'd5; in_sub = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid, out_sum} !== {1'b0, 1'b1, 4'd4}) begin
                errors++;
                $display("FAIL hold[%0d]: rdy=%b vld=%b sum=%0d want 0 1 4", i, in_ready, out_valid, out_sum);
            end
        end
        in_valid = 1'b0;
        accept_result();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 4'd4) begin
            errors++;
            $display("FAIL hold_release: rdy=%b vld=%b sum=%0d want 1 0 4", in_ready, out_valid, out_sum);
        end
    endtask

    task automatic test_seq_err();
        bit ok;
        drive_beat(0, 1, 0, 4'd3, ok);
        checks++;
        if ({ok, err_seq, out_valid} !== {1'b1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL err_idle: ok=%b err=%b vld=%b want 1 1 0", ok, err_seq, out_valid);
        end
        @(negedge clk);
        checks++;
        if (err_seq !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL err_pulse: err=%b vld=%b want 0 0", err_seq, out_valid);
        end
        drive_beat(1, 0, 0, 4'd7, ok);
        drive_beat(1, 0, 0, 4'd2, ok);
        checks++;
        if (err_seq !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL err_restart: err=%b vld=%b want 1 0", err_seq, out_valid);
        end
        drive_beat(0, 1, 0, 4'd2, ok);
        checks++;
        if ({out_valid, err_seq, out_sum, out_count, out_ovf, out_trunc} !==
            {1'b1, 1'b0, 4'd4, CW'(2), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL restart_result: vld=%b err=%b sum=%0d cnt=%0d ovf=%b tr=%b want 1 0 4 2 0 0",
                     out_valid, err_seq, out_sum, out_count, out_ovf, out_trunc);
        end
        accept_result();
    endtask

    task automatic test_reset_mid();
        bit ok;
        drive_beat(1, 0, 0, 4'd5, ok);
        drive_beat(0, 0, 0, 4'd6, ok);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_sum, out_ovf, out_trunc, out_count, err_seq} !==
            {1'b1, 1'b0, W'(0), 1'b0, 1'b0, CW'(0), 1'b0}) begin
            errors++;
            $display("FAIL reset_async: rdy=%b vld=%b sum=%0d ovf=%b tr=%b cnt=%0d err=%b, want rdy=1 rest 0",
                     in_ready, out_valid, out_sum, out_ovf, out_trunc, out_count, err_seq);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        drive_beat(1, 0, 0, 4'd1, ok);
        drive_beat(0, 1, 0, 4'd1, ok);
        checks++;
        if ({out_valid, out_sum, out_count} !== {1'b1, 4'd2, CW'(2)}) begin
            errors++;
            $display("FAIL after_reset: vld=%b sum=%0d cnt=%0d want 1 2 2", out_valid, out_sum, out_count);
        end
        accept_result();
    endtask

    task automatic test_random();
        int  d[MO];
        bit  s[MO];
        bit  l[MO];
        int  n, exp_sum, exp_cnt;
        bit  exp_ovf, exp_tr, ok;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, MO);
            for (int i = 0; i < MO; i++) begin
                d[i] = $urandom_range(0, MOD - 1);
                s[i] = $urandom_range(0, 1);
                l[i] = 1'b0;
            end
            l[n-1] = (n < MO) ? 1'b1 : 1'($urandom_range(0, 1));
            model_frame(n, d, s, l, exp_sum, exp_ovf, exp_cnt, exp_tr);
            for (int i = 0; i < n; i++) begin
                drive_beat(i == 0, l[i], s[i], W'(d[i]), ok);
                if ($urandom_range(0, 3) == 0 && i < n - 1) @(negedge clk);
            end
            checks++;
            if ({ok, out_valid, out_sum, out_ovf, out_count, out_trunc} !==
                {1'b1, 1'b1, W'(exp_sum), exp_ovf, CW'(exp_cnt), exp_tr}) begin
                errors++;
                $display("FAIL random[%0d]: ok=%b vld=%b sum=%0d ovf=%b cnt=%0d tr=%b want 1 1 %0d %b %0d %b",
                         f, ok, out_valid, out_sum, out_ovf, out_count, out_trunc,
                         exp_sum, exp_ovf, exp_cnt, exp_tr);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept_result();
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_sub    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_trunc_backpressure();
        test_seq_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
